// File: rtl/sdr_chk_pkg.sv
// sdr_chk_pkg: command/error encodings, timer width and pin-pattern decode for the SDRAM command checker.
package sdr_chk_pkg;

    localparam int TMR_W = 8;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_READ,
        CMD_WRITE,
        CMD_PRE,
        CMD_REF,
        CMD_MRS,
        CMD_BST
    } cmd_e;

    typedef enum logic [3:0] {
        ERR_NONE,
        ERR_TRFC,
        ERR_ACT_OPEN,
        ERR_TRP,
        ERR_RW_IDLE,
        ERR_TRCD,
        ERR_REF_OPEN,
        ERR_MRS_OPEN,
        ERR_MRS_VAL
    } err_e;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] PIN_NOP   = 4'b0111;
    localparam logic [3:0] PIN_ACT   = 4'b0011;
    localparam logic [3:0] PIN_READ  = 4'b0101;
    localparam logic [3:0] PIN_WRITE = 4'b0100;
    localparam logic [3:0] PIN_PRE   = 4'b0010;
    localparam logic [3:0] PIN_REF   = 4'b0001;
    localparam logic [3:0] PIN_MRS   = 4'b0000;
    localparam logic [3:0] PIN_BST   = 4'b0110;

    function automatic cmd_e decode_cmd(input logic [3:0] p);
        return (p[3] || p == PIN_NOP) ? CMD_NOP   :
               (p == PIN_ACT)         ? CMD_ACT   :
               (p == PIN_READ)        ? CMD_READ  :
               (p == PIN_WRITE)       ? CMD_WRITE :
               (p == PIN_PRE)         ? CMD_PRE   :
               (p == PIN_REF)         ? CMD_REF   :
               (p == PIN_MRS)         ? CMD_MRS   :
               (p == PIN_BST)         ? CMD_BST   : CMD_NOP;
    endfunction

endpackage

// File: rtl/sdr_bank_tracker.sv
// sdr_bank_tracker: one SDRAM bank's open/idle state, open row and tRCD/tRP countdown timers.
module sdr_bank_tracker
    import sdr_chk_pkg::*;
#(
    parameter int TRCD_CK = 3,
    parameter int TRP_CK  = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        act_i,
    input  logic        pre_i,
    input  logic [12:0] row_i,
    output logic        open_o,
    output logic [12:0] row_o,
    output logic        trcd_zero_o,
    output logic        trp_zero_o
);

    logic             open_q, open_d;
    logic [12:0]      row_q, row_d;
    logic [TMR_W-1:0] trcd_q, trcd_d;
    logic [TMR_W-1:0] trp_q, trp_d;

    // Timers load on their command and otherwise count down, saturating at zero.
    always_comb begin
        open_d = act_i ? 1'b1 : pre_i ? 1'b0 : open_q;
        row_d  = act_i ? row_i : row_q;
        trcd_d = act_i ? TMR_W'(TRCD_CK - 1) : trcd_q - TMR_W'(trcd_q != '0);
        trp_d  = pre_i ? TMR_W'(TRP_CK - 1) : trp_q - TMR_W'(trp_q != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            open_q <= 1'b0;
            row_q  <= '0;
            trcd_q <= '0;
            trp_q  <= '0;
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
            trcd_q <= trcd_d;
            trp_q  <= trp_d;
        end
    end

    assign open_o      = open_q;
    assign row_o       = row_q;
    assign trcd_zero_o = trcd_q == '0;
    assign trp_zero_o  = trp_q == '0;

endmodule

// File: rtl/sdr_cmd_checker.sv
// sdr_cmd_checker: SDRAM pin-side command decoder and tRCD/tRP/tRFC/bank-state protocol checker.
// Optional SDR_CMD_STATS_EN adds saturating ACT/READ/WRITE/REF counters.
module sdr_cmd_checker
    import sdr_chk_pkg::*;
#(
    parameter int TRCD_CK = 3,
    parameter int TRP_CK  = 3,
    parameter int TRFC_CK = 7
`ifdef SDR_CMD_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic             sdram_clk,
    input  logic             sdram_resetn,
    input  logic             mon_en,
    input  logic             sdr_cs_n,
    input  logic             sdr_ras_n,
    input  logic             sdr_cas_n,
    input  logic             sdr_we_n,
    input  logic [1:0]       sdr_ba,
    input  logic [12:0]      sdr_addr,
    input  logic [12:0]      cfg_sdr_mode_reg,
    input  logic             err_clr,
`ifdef SDR_CMD_STATS_EN
    output logic [CNT_W-1:0] act_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] ref_cnt,
`endif
    output logic             cmd_vld,
    output logic [2:0]       cmd_code,
    output logic [1:0]       cmd_ba,
    output logic [3:0]       bank_open,
    output logic             err_vld,
    output logic [3:0]       err_code,
    output logic             err_sticky
);

    cmd_e             cmd;
    err_e             err;
    logic             valid, is_rw, any_open;
    logic [3:0]       act_hit, pre_hit, open_v, trcd_z, trp_z;
    // Open rows are tracked for debug visibility; no rule checks them.
    logic [12:0]      row_unused [4];
    logic [TMR_W-1:0] trfc_q, trfc_d;
    logic             cmd_vld_q, cmd_vld_d;
    cmd_e             cmd_code_q, cmd_code_d;
    logic [1:0]       cmd_ba_q, cmd_ba_d;
    logic             err_vld_q, err_vld_d;
    err_e             err_code_q, err_code_d;
    logic             err_sticky_q, err_sticky_d;

    always_comb begin
        cmd          = decode_cmd({sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n});
        valid        = cmd != CMD_NOP;
        is_rw        = cmd == CMD_READ || cmd == CMD_WRITE;
        any_open     = |open_v;
        err          = (valid && trfc_q != '0)                   ? ERR_TRFC     :
                       (cmd == CMD_ACT && open_v[sdr_ba])        ? ERR_ACT_OPEN :
                       (cmd == CMD_ACT && !trp_z[sdr_ba])        ? ERR_TRP      :
                       (is_rw && !open_v[sdr_ba])                ? ERR_RW_IDLE  :
                       (is_rw && !trcd_z[sdr_ba])                ? ERR_TRCD     :
                       (cmd == CMD_REF && any_open)              ? ERR_REF_OPEN :
                       (cmd == CMD_MRS && any_open)              ? ERR_MRS_OPEN :
                       (cmd == CMD_MRS && sdr_addr != cfg_sdr_mode_reg) ? ERR_MRS_VAL : ERR_NONE;
        trfc_d       = (mon_en && cmd == CMD_REF) ? TMR_W'(TRFC_CK - 1) : trfc_q - TMR_W'(trfc_q != '0);
        cmd_vld_d    = mon_en && valid;
        cmd_code_d   = mon_en ? cmd : cmd_code_q;
        cmd_ba_d     = mon_en ? sdr_ba : cmd_ba_q;
        err_vld_d    = mon_en && err != ERR_NONE;
        err_code_d   = mon_en ? err : err_code_q;
        err_sticky_d = err_vld_d || (err_sticky_q && !err_clr);
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        assign act_hit[b] = mon_en && cmd == CMD_ACT && sdr_ba == 2'(b);
        // PRE-all and auto-precharge (READ/WRITE with A10) close banks too.
        assign pre_hit[b] = mon_en && ((cmd == CMD_PRE && (sdr_addr[10] || sdr_ba == 2'(b))) ||
                                       (is_rw && sdr_addr[10] && sdr_ba == 2'(b)));
        sdr_bank_tracker #(
            .TRCD_CK(TRCD_CK),
            .TRP_CK (TRP_CK)
        ) u_bank (
            .clk_i      (sdram_clk),
            .rst_ni     (sdram_resetn),
            .act_i      (act_hit[b]),
            .pre_i      (pre_hit[b]),
            .row_i      (sdr_addr),
            .open_o     (open_v[b]),
            .row_o      (row_unused[b]),
            .trcd_zero_o(trcd_z[b]),
            .trp_zero_o (trp_z[b])
        );
    end

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            trfc_q       <= '0;
            cmd_vld_q    <= 1'b0;
            cmd_code_q   <= CMD_NOP;
            cmd_ba_q     <= '0;
            err_vld_q    <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_sticky_q <= 1'b0;
        end else begin
            trfc_q       <= trfc_d;
            cmd_vld_q    <= cmd_vld_d;
            cmd_code_q   <= cmd_code_d;
            cmd_ba_q     <= cmd_ba_d;
            err_vld_q    <= err_vld_d;
            err_code_q   <= err_code_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign cmd_vld    = cmd_vld_q;
    assign cmd_code   = cmd_code_q;
    assign cmd_ba     = cmd_ba_q;
    assign bank_open  = open_v;
    assign err_vld    = err_vld_q;
    assign err_code   = err_code_q;
    assign err_sticky = err_sticky_q;

`ifdef SDR_CMD_STATS_EN
    logic [CNT_W-1:0] act_cnt_q, rd_cnt_q, wr_cnt_q, ref_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
        return c + CNT_W'(hit && c != '1);
    endfunction

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn || err_clr) begin
            act_cnt_q <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            ref_cnt_q <= '0;
        end else begin
            act_cnt_q <= sat_inc(act_cnt_q, mon_en && cmd == CMD_ACT);
            rd_cnt_q  <= sat_inc(rd_cnt_q, mon_en && cmd == CMD_READ);
            wr_cnt_q  <= sat_inc(wr_cnt_q, mon_en && cmd == CMD_WRITE);
            ref_cnt_q <= sat_inc(ref_cnt_q, mon_en && cmd == CMD_REF);
        end
    end

    assign act_cnt = act_cnt_q;
    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign ref_cnt = ref_cnt_q;
`endif

endmodule
